regfile_scoreboard: RTL and testbench

//  Parametrised successor to the decode-stage register file: NUM_RD combinational read ports,
//  one write port, optional write-to-read bypass, and a per-register busy scoreboard for
//  in-flight destination writes. Sits in ID; issue marks rd pending, WB clears it;

---
 rtl/regfile_scoreboard.sv | 84 ++++++++
 tb/tb_regfile_scoreboard.sv | 272 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/regfile_scoreboard.sv
// Decode-stage register file with combinational read ports, one write port, optional
// WB-to-read forwarding and a per-register busy scoreboard that raises stall on RAW hazards.
module regfile_scoreboard #(
  parameter  int XLEN   = 32,
  parameter  int NREGS  = 32,
  parameter  int NUM_RD = 2,
  parameter  int BYPASS = 1,
  localparam int AW     = $clog2(NREGS),
  localparam int CW     = $clog2(NREGS + 1)
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [NUM_RD*AW-1:0]   rd_addr,
  input  logic [NUM_RD-1:0]      rd_use,
  output logic [NUM_RD*XLEN-1:0] rd_data,
  output logic [NUM_RD-1:0]      rd_hazard,
  output logic                   stall,
  input  logic                   iss_en,
  input  logic [AW-1:0]          iss_addr,
  input  logic                   wr_en,
  input  logic [AW-1:0]          wr_addr,
  input  logic [XLEN-1:0]        wr_data,
  output logic [NREGS-1:0]       busy_vec,
  output logic [CW-1:0]          busy_cnt
);

  logic [XLEN-1:0]  rf_q [NREGS];
  logic [NREGS-1:0] busy_q, busy_d;
  logic [CW-1:0]    busy_cnt_q, busy_cnt_d;
  logic             iss_fire;

  function automatic logic [CW-1:0] popcount(input logic [NREGS-1:0] v);
    logic [CW-1:0] n;
    n = '0;
    for (int i = 0; i < NREGS; i++) n = n + CW'(v[i]);
    return n;
  endfunction

  // Forwarding is suppressed while reset is held so every read port reads zero at once.
  for (genvar p = 0; p < NUM_RD; p++) begin : g_rd
    logic [AW-1:0] ra;
    logic          fwd;
    assign ra  = rd_addr[p*AW +: AW];
    assign fwd = (BYPASS != 0) && wr_en && !reset && (wr_addr == ra);
    assign rd_data[p*XLEN +: XLEN] = (ra == '0) ? '0 : (fwd ? wr_data : rf_q[ra]);
    assign rd_hazard[p] = busy_q[ra] && (ra != '0) && !fwd;
  end

  assign stall    = |(rd_hazard & rd_use);
  assign iss_fire = iss_en && !stall && (iss_addr != '0);

  // Issue wins over writeback on the same register: the younger instruction still owns it.
  always_comb begin
    busy_d = busy_q;
    for (int r = 1; r < NREGS; r++) begin
      if (iss_fire && (iss_addr == AW'(r)))   busy_d[r] = 1'b1;
      else if (wr_en && (wr_addr == AW'(r)))  busy_d[r] = 1'b0;
    end
    busy_d[0]  = 1'b0;
    busy_cnt_d = popcount(busy_d);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      busy_q     <= '0;
      busy_cnt_q <= '0;
    end else begin
      busy_q     <= busy_d;
      busy_cnt_q <= busy_cnt_d;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < NREGS; i++) rf_q[i] <= '0;
    end else if (wr_en && (wr_addr != '0)) begin
      rf_q[wr_addr] <= wr_data;
    end
  end

  assign busy_vec = busy_q;
  assign busy_cnt = busy_cnt_q;

endmodule

// File: tb/tb_regfile_scoreboard.sv
// Bench for regfile_scoreboard: one instance with and one without forwarding, directed
// scenarios followed by random traffic, all checked against an array-based reference model.
module tb_regfile_scoreboard;

  localparam int XLEN   = 32;
  localparam int NREGS  = 32;
  localparam int NUM_RD = 2;
  localparam int AW     = 5;
  localparam int CW     = 6;

  logic                   clk = 1'b0;
  logic                   reset = 1'b0;
  logic [NUM_RD*AW-1:0]   rd_addr;
  logic [NUM_RD-1:0]      rd_use;
  logic                   iss_en;
  logic [AW-1:0]          iss_addr;
  logic                   wr_en;
  logic [AW-1:0]          wr_addr;
  logic [XLEN-1:0]        wr_data;

  logic [NUM_RD*XLEN-1:0] rd_data   [2];
  logic [NUM_RD-1:0]      rd_hazard [2];
  logic                   stall     [2];
  logic [NREGS-1:0]       busy_vec  [2];
  logic [CW-1:0]          busy_cnt  [2];

  // Index 0: no forwarding, index 1: forwarding.
  logic [XLEN-1:0] rf_m   [NREGS];
  bit              busy_m [2][NREGS];

  int n_chk  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  regfile_scoreboard #(.XLEN(XLEN), .NREGS(NREGS), .NUM_RD(NUM_RD), .BYPASS(0)) u_nobyp (
    .clk(clk), .reset(reset), .rd_addr(rd_addr), .rd_use(rd_use),
    .rd_data(rd_data[0]), .rd_hazard(rd_hazard[0]), .stall(stall[0]),
    .iss_en(iss_en), .iss_addr(iss_addr), .wr_en(wr_en), .wr_addr(wr_addr),
    .wr_data(wr_data), .busy_vec(busy_vec[0]), .busy_cnt(busy_cnt[0])
  );

  regfile_scoreboard #(.XLEN(XLEN), .NREGS(NREGS), .NUM_RD(NUM_RD), .BYPASS(1)) u_byp (
    .clk(clk), .reset(reset), .rd_addr(rd_addr), .rd_use(rd_use),
    .rd_data(rd_data[1]), .rd_hazard(rd_hazard[1]), .stall(stall[1]),
    .iss_en(iss_en), .iss_addr(iss_addr), .wr_en(wr_en), .wr_addr(wr_addr),
    .wr_data(wr_data), .busy_vec(busy_vec[1]), .busy_cnt(busy_cnt[1])
  );

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic logic [XLEN-1:0] exp_rd(input int d, input logic [AW-1:0] a);
    if (reset || a == 0) return '0;
    if (d == 1 && wr_en && wr_addr == a) return wr_data;
    return rf_m[a];
  endfunction

  function automatic bit exp_haz(input int d, input logic [AW-1:0] a);
    return busy_m[d][a] && (a != 0) && !(d == 1 && wr_en && wr_addr == a);
  endfunction

  function automatic bit exp_stall(input int d);
    for (int p = 0; p < NUM_RD; p++)
      if (rd_use[p] && exp_haz(d, rd_addr[p*AW +: AW])) return 1'b1;
    return 1'b0;
  endfunction

  task automatic model_clear();
    for (int r = 0; r < NREGS; r++) begin
      rf_m[r] = '0;
      busy_m[0][r] = 0;
      busy_m[1][r] = 0;
    end
  endtask

  task automatic check_all(input string tag);
    logic [NREGS-1:0] ev;
    int               ec;
    for (int d = 0; d < 2; d++) begin
      for (int p = 0; p < NUM_RD; p++) begin
        check_eq($sformatf("%s_d%0d_data%0d", tag, d, p), 64'(rd_data[d][p*XLEN +: XLEN]),
                 64'(exp_rd(d, rd_addr[p*AW +: AW])));
        check_eq($sformatf("%s_d%0d_haz%0d", tag, d, p), 64'(rd_hazard[d][p]),
                 64'(exp_haz(d, rd_addr[p*AW +: AW])));
      end
      check_eq($sformatf("%s_d%0d_stall", tag, d), 64'(stall[d]), 64'(exp_stall(d)));
      ec = 0;
      for (int r = 0; r < NREGS; r++) begin
        ev[r] = busy_m[d][r];
        ec += int'(busy_m[d][r]);
      end
      check_eq($sformatf("%s_d%0d_busyvec", tag, d), 64'(busy_vec[d]), 64'(ev));
      check_eq($sformatf("%s_d%0d_busycnt", tag, d), 64'(busy_cnt[d]), 64'(ec));
    end
  endtask

  // Entered and left on a falling edge; inputs must already be set.
  task automatic cyc(input string tag);
    bit fire [2];
    #1;
    check_all(tag);
    for (int d = 0; d < 2; d++) fire[d] = iss_en && !exp_stall(d) && (iss_addr != 0);
    @(posedge clk);
    if (wr_en && wr_addr != 0) rf_m[wr_addr] = wr_data;
    for (int d = 0; d < 2; d++) begin
      if (wr_en)   busy_m[d][wr_addr]  = 0;
      if (fire[d]) busy_m[d][iss_addr] = 1;
      busy_m[d][0] = 0;
    end
    @(negedge clk);
  endtask

  task automatic idle();
    rd_addr = '0;
    rd_use  = '0;
    iss_en  = 1'b0;
    iss_addr = '0;
    wr_en   = 1'b0;
    wr_addr = '0;
    wr_data = '0;
  endtask

  task automatic rst_pulse(input string tag);
    reset = 1'b1;
    #1;
    model_clear();
    check_all(tag);
    #1;
    reset = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    idle();
    rd_addr = {5'd5, 5'd3};
    #1 reset = 1'b1;
    #1;
    model_clear();
    check_all("reset");
    for (int d = 0; d < 2; d++) check_eq("reset_cnt", 64'(busy_cnt[d]), 64'd0);
    @(negedge clk);
    reset = 1'b0;

    // Write then read back; x0 stays zero.
    idle(); wr_en = 1'b1; wr_addr = 5'd5; wr_data = 32'hDEADBEEF;
    cyc("wr5");
    idle(); rd_addr = {5'd5, 5'd5};
    #1;
    for (int d = 0; d < 2; d++)
      for (int p = 0; p < 2; p++)
        check_eq("rd5", 64'(rd_data[d][p*XLEN +: XLEN]), 64'h0000_0000_DEAD_BEEF);
    cyc("rd5c");
    idle(); wr_en = 1'b1; wr_addr = 5'd0; wr_data = 32'h1234;
    cyc("wr0");
    idle();
    #1;
    for (int d = 0; d < 2; d++) check_eq("rd0", 64'(rd_data[d][XLEN-1:0]), 64'd0);
    cyc("rd0c");

    // RAW hazard on x7.
    idle(); iss_en = 1'b1; iss_addr = 5'd7;
    cyc("iss7");
    idle(); rd_addr = {5'd0, 5'd7}; rd_use = 2'b01;
    #1;
    for (int d = 0; d < 2; d++) begin
      check_eq("raw_haz", 64'(rd_hazard[d][0]), 64'd1);
      check_eq("raw_stall", 64'(stall[d]), 64'd1);
      check_eq("raw_cnt", 64'(busy_cnt[d]), 64'd1);
    end
    cyc("raw");
    rd_use = 2'b00;
    #1;
    for (int d = 0; d < 2; d++) begin
      check_eq("raw_nouse_haz", 64'(rd_hazard[d][0]), 64'd1);
      check_eq("raw_nouse_stall", 64'(stall[d]), 64'd0);
    end
    cyc("rawnu");

    // Writeback of x7 while it is being read.
    rd_use = 2'b01; wr_en = 1'b1; wr_addr = 5'd7; wr_data = 32'hA5A5A5A5;
    #1;
    check_eq("byp_data", 64'(rd_data[1][XLEN-1:0]), 64'hA5A5A5A5);
    check_eq("byp_haz", 64'(rd_hazard[1][0]), 64'd0);
    check_eq("nobyp_haz", 64'(rd_hazard[0][0]), 64'd1);
    check_eq("nobyp_stall", 64'(stall[0]), 64'd1);
    cyc("byp");
    idle(); rd_addr = {5'd0, 5'd7}; rd_use = 2'b01;
    #1;
    check_eq("nobyp_data_next", 64'(rd_data[0][XLEN-1:0]), 64'hA5A5A5A5);
    check_eq("nobyp_haz_next", 64'(rd_hazard[0][0]), 64'd0);
    cyc("bypn");

    // Issue and writeback of x9 in the same cycle; stalled issue of x3.
    idle(); iss_en = 1'b1; iss_addr = 5'd9;
    cyc("iss9");
    iss_en = 1'b1; iss_addr = 5'd9; wr_en = 1'b1; wr_addr = 5'd9; wr_data = 32'h99;
    cyc("waw9");
    idle(); rd_addr = {5'd0, 5'd9};
    #1;
    for (int d = 0; d < 2; d++) begin
      check_eq("waw_busy9", 64'(busy_vec[d][9]), 64'd1);
      check_eq("waw_cnt", 64'(busy_cnt[d]), 64'd1);
      check_eq("waw_data", 64'(rd_data[d][XLEN-1:0]), 64'h99);
    end
    rd_use = 2'b01; iss_en = 1'b1; iss_addr = 5'd3;
    cyc("stall3");
    idle();
    #1;
    for (int d = 0; d < 2; d++) check_eq("stall_busy3", 64'(busy_vec[d][3]), 64'd0);
    wr_en = 1'b1; wr_addr = 5'd9; wr_data = 32'h900;
    cyc("clr9");

    // Fill the scoreboard, drain it, then reset part way through a refill.
    for (int i = 1; i < NREGS; i++) begin
      idle(); iss_en = 1'b1; iss_addr = AW'(i);
      cyc("fill");
    end
    idle();
    #1;
    for (int d = 0; d < 2; d++) begin
      check_eq("fill_cnt", 64'(busy_cnt[d]), 64'd31);
      check_eq("fill_vec", 64'(busy_vec[d]), 64'hFFFF_FFFE);
    end
    for (int i = 1; i < NREGS; i++) begin
      idle(); wr_en = 1'b1; wr_addr = AW'(i); wr_data = $urandom;
      cyc("drain");
    end
    idle();
    #1;
    for (int d = 0; d < 2; d++) check_eq("drain_cnt", 64'(busy_cnt[d]), 64'd0);
    for (int i = 1; i < 16; i++) begin
      idle(); iss_en = 1'b1; iss_addr = AW'(i); rd_addr = {AW'(i), 5'd5};
      cyc("refill");
    end
    rst_pulse("midrst");
    for (int d = 0; d < 2; d++) check_eq("midrst_cnt", 64'(busy_cnt[d]), 64'd0);

    // Random traffic, with narrow address ranges to provoke collisions.
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 199) == 0) rst_pulse("rrst");
      if ($urandom_range(0, 3) == 0) begin
        rd_addr  = {5'($urandom_range(0, 31)), 5'($urandom_range(0, 31))};
        iss_addr = 5'($urandom_range(0, 31));
        wr_addr  = 5'($urandom_range(0, 31));
      end else begin
        rd_addr  = {5'($urandom_range(0, 7)), 5'($urandom_range(0, 7))};
        iss_addr = 5'($urandom_range(0, 7));
        wr_addr  = 5'($urandom_range(0, 7));
      end
      rd_use  = 2'($urandom);
      iss_en  = ($urandom_range(0, 2) != 0);
      wr_en   = ($urandom_range(0, 1) != 0);
      wr_data = $urandom;
      cyc("rnd");
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
